// File: rtl/sbus_pkg.sv
// Shared definitions for the S.BUS receive path: frame constants,
// flag bit positions and the frame sequencer state encoding.
package sbus_pkg;

  typedef enum logic [2:0] {
    WAIT_GAP,
    HDR,
    DATA,
    FLAGS,
    FOOTER,
    COMMIT
  } sbus_state_e;

  localparam logic [7:0] SBUS_HDR = 8'h0F;
  localparam logic [7:0] SBUS_FTR = 8'h00;

  localparam int unsigned SBUS_NCH   = 16;
  localparam int unsigned SBUS_CHW   = 11;
  localparam int unsigned SBUS_NDATA = 22;

  localparam int unsigned FLAG_CH17 = 0;
  localparam int unsigned FLAG_CH18 = 1;
  localparam int unsigned FLAG_FS   = 3;

  // S.BUS2 footers 0x04/0x14/0x24/0x34
  function automatic logic is_sbus2_ftr(input logic [7:0] b);
    return (b[7:6] == 2'b00) && (b[3:0] == 4'h4);
  endfunction

endpackage

// File: rtl/sbus_ch_unpack.sv
// Bit accumulator that turns the 22 S.BUS data bytes into 16 11-bit
// channel writes, LSB-first, at most one registered write per byte.
module sbus_ch_unpack
  import sbus_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                byte_stb,
  input  logic [7:0]          byte_data,
  output logic                ch_we,
  output logic [3:0]          ch_addr,
  output logic [SBUS_CHW-1:0] ch_data
);

  localparam int unsigned ACC_W = 19;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [4:0]       nbits;
  logic [4:0]       nb_sum;
  logic [3:0]       ch_idx;
  logic             ch_full;

  always_comb begin
    acc_sum = acc | (ACC_W'(byte_data) << nbits);
    nb_sum  = nbits + 5'd8;
    ch_full = (nb_sum >= 5'(SBUS_CHW));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      nbits   <= '0;
      ch_idx  <= '0;
      ch_we   <= 1'b0;
      ch_addr <= '0;
      ch_data <= '0;
    end else if (clr) begin
      acc    <= '0;
      nbits  <= '0;
      ch_idx <= '0;
      ch_we  <= 1'b0;
    end else begin
      ch_we <= 1'b0;
      if (byte_stb) begin
        if (ch_full) begin
          ch_we   <= 1'b1;
          ch_addr <= ch_idx;
          ch_data <= acc_sum[SBUS_CHW-1:0];
          acc     <= acc_sum >> SBUS_CHW;
          nbits   <= nb_sum - 5'(SBUS_CHW);
          ch_idx  <= ch_idx + 4'd1;
        end else begin
          acc   <= acc_sum;
          nbits <= nb_sum;
        end
      end
    end
  end

endmodule

// File: rtl/sbus_frame_ctrl.sv
// S.BUS frame sequencer: gap-qualified header search, channel unpacking,
// flags/footer check, commit/abort pulses, and link-loss supervision.
module sbus_frame_ctrl
  import sbus_pkg::*;
#(
  parameter int unsigned GAP_CYC     = 10000,
  parameter int unsigned BYTE_TO_CYC = 15000,
  parameter int unsigned LOST_CYC    = 5000000,
  parameter bit          SBUS2_EN    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        byte_err,
  output logic        ch_we,
  output logic [3:0]  ch_addr,
  output logic [10:0] ch_data,
  output logic        frame_ok,
  output logic        frame_abort,
  output logic        ch17,
  output logic        ch18,
  output logic        failsafe,
  output logic        link_lost,
  output logic [7:0]  err_cnt
);

  localparam int unsigned GAP_W  = $clog2(GAP_CYC + 1);
  localparam int unsigned BTO_W  = $clog2(BYTE_TO_CYC + 1);
  localparam int unsigned LOST_W = $clog2(LOST_CYC + 1);
  localparam int unsigned IDX_W  = $clog2(SBUS_NCH + 1);

  sbus_state_e       state, state_n;
  logic [GAP_W-1:0]  gap_cnt;
  logic [BTO_W-1:0]  bto_cnt;
  logic [LOST_W-1:0] lost_cnt;
  logic [IDX_W-1:0]  byte_idx;
  logic              fl_ch17, fl_ch18, fl_fs, fs_flag;

  logic byte_ok, bto_hit, ftr_good, in_frame;
  logic abort_n, unp_clr, unp_stb, flags_ld;

  always_comb begin
    byte_ok  = byte_valid && !byte_err;
    bto_hit  = !byte_valid && (bto_cnt == BTO_W'(BYTE_TO_CYC));
    ftr_good = (byte_data == SBUS_FTR) || (SBUS2_EN && is_sbus2_ftr(byte_data));
    in_frame = (state == DATA) || (state == FLAGS) || (state == FOOTER);
  end

  always_comb begin
    state_n  = state;
    abort_n  = 1'b0;
    unp_clr  = 1'b0;
    unp_stb  = 1'b0;
    flags_ld = 1'b0;
    unique case (state)
      WAIT_GAP: if (!byte_valid && gap_cnt == GAP_W'(GAP_CYC)) state_n = HDR;
      HDR: begin
        if (byte_valid) begin
          if (byte_ok && byte_data == SBUS_HDR) begin
            state_n = DATA;
            unp_clr = 1'b1;
          end else begin
            state_n = WAIT_GAP;
          end
        end
      end
      DATA: begin
        if ((byte_valid && byte_err) || bto_hit) begin
          abort_n = 1'b1;
        end else if (byte_valid) begin
          unp_stb = 1'b1;
          if (byte_idx == IDX_W'(SBUS_NDATA - 1)) state_n = FLAGS;
        end
      end
      FLAGS: begin
        if ((byte_valid && byte_err) || bto_hit) begin
          abort_n = 1'b1;
        end else if (byte_valid) begin
          flags_ld = 1'b1;
          state_n  = FOOTER;
        end
      end
      FOOTER: begin
        if (bto_hit) begin
          abort_n = 1'b1;
        end else if (byte_valid) begin
          if (byte_ok && ftr_good) state_n = COMMIT;
          else                     abort_n = 1'b1;
        end
      end
      COMMIT:  state_n = WAIT_GAP;
      default: state_n = WAIT_GAP;
    endcase
    if (abort_n) state_n = WAIT_GAP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_GAP;
      gap_cnt     <= '0;
      bto_cnt     <= '0;
      lost_cnt    <= '0;
      byte_idx    <= '0;
      fl_ch17     <= 1'b0;
      fl_ch18     <= 1'b0;
      fl_fs       <= 1'b0;
      fs_flag     <= 1'b0;
      link_lost   <= 1'b1;
      frame_ok    <= 1'b0;
      frame_abort <= 1'b0;
      ch17        <= 1'b0;
      ch18        <= 1'b0;
      err_cnt     <= '0;
    end else begin
      state       <= state_n;
      frame_ok    <= (state == COMMIT);
      frame_abort <= abort_n;

      if (byte_valid || state == COMMIT || abort_n)
        gap_cnt <= '0;
      else if (state == WAIT_GAP && gap_cnt != GAP_W'(GAP_CYC))
        gap_cnt <= gap_cnt + 1'b1;

      if (byte_valid || !in_frame)
        bto_cnt <= '0;
      else if (bto_cnt != BTO_W'(BYTE_TO_CYC))
        bto_cnt <= bto_cnt + 1'b1;

      if (unp_clr)      byte_idx <= '0;
      else if (unp_stb) byte_idx <= byte_idx + 1'b1;

      // only the flag bits this block acts on are held
      if (flags_ld) begin
        fl_ch17 <= byte_data[FLAG_CH17];
        fl_ch18 <= byte_data[FLAG_CH18];
        fl_fs   <= byte_data[FLAG_FS];
      end

      if (state == COMMIT) begin
        ch17      <= fl_ch17;
        ch18      <= fl_ch18;
        fs_flag   <= fl_fs;
        lost_cnt  <= '0;
        link_lost <= 1'b0;
      end else if (lost_cnt != LOST_W'(LOST_CYC)) begin
        lost_cnt <= lost_cnt + 1'b1;
      end else begin
        link_lost <= 1'b1;
      end

      if (abort_n && err_cnt != '1) err_cnt <= err_cnt + 8'd1;
    end
  end

  assign failsafe = fs_flag | link_lost;

  sbus_ch_unpack u_unpack (
    .clk      (clk),
    .rst      (rst),
    .clr      (unp_clr),
    .byte_stb (unp_stb),
    .byte_data(byte_data),
    .ch_we    (ch_we),
    .ch_addr  (ch_addr),
    .ch_data  (ch_data)
  );

endmodule

// File: tb/tb_sbus_frame_ctrl.sv
// Scoreboard bench for sbus_frame_ctrl with timing parameters scaled down;
// a second instance with S.BUS2 footers enabled shares the byte stream.
module tb_sbus_frame_ctrl;

  localparam int unsigned GAP  = 1000;
  localparam int unsigned BTO  = 1500;
  localparam int unsigned LOST = 20000;

  logic        clk = 1'b0;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_err;

  logic        ch_we, frame_ok, frame_abort, ch17, ch18, failsafe, link_lost;
  logic [3:0]  ch_addr;
  logic [10:0] ch_data;
  logic [7:0]  err_cnt;

  logic        b_ch_we, b_frame_ok, b_frame_abort, b_ch17, b_ch18, b_failsafe, b_link_lost;
  logic [3:0]  b_ch_addr;
  logic [10:0] b_ch_data;
  logic [7:0]  b_err_cnt;

  typedef struct {
    logic [3:0]  a;
    logic [10:0] d;
    int unsigned cyc;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          fails = 0;
  int          ok0 = 0, ab0 = 0, ok1 = 0, ab1 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sbus_frame_ctrl #(.GAP_CYC(GAP), .BYTE_TO_CYC(BTO), .LOST_CYC(LOST), .SBUS2_EN(1'b0)) u_dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data), .byte_err(byte_err),
    .ch_we(ch_we), .ch_addr(ch_addr), .ch_data(ch_data), .frame_ok(frame_ok),
    .frame_abort(frame_abort), .ch17(ch17), .ch18(ch18), .failsafe(failsafe),
    .link_lost(link_lost), .err_cnt(err_cnt)
  );

  sbus_frame_ctrl #(.GAP_CYC(GAP), .BYTE_TO_CYC(BTO), .LOST_CYC(LOST), .SBUS2_EN(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data), .byte_err(byte_err),
    .ch_we(b_ch_we), .ch_addr(b_ch_addr), .ch_data(b_ch_data), .frame_ok(b_frame_ok),
    .frame_abort(b_frame_abort), .ch17(b_ch17), .ch18(b_ch18), .failsafe(b_failsafe),
    .link_lost(b_link_lost), .err_cnt(b_err_cnt)
  );

  task automatic scoreboard_mon();
    wr_t e;
    forever begin
      @(negedge clk);
      if (frame_ok)      ok0++;
      if (frame_abort)   ab0++;
      if (b_frame_ok)    ok1++;
      if (b_frame_abort) ab1++;
      if (ch_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL ch_write_unexpected: got addr %0d data %h at cycle %0d, required no write",
                   ch_addr, ch_data, cyc);
        end else begin
          e = exp_q.pop_front();
          if (ch_addr !== e.a || ch_data !== e.d || cyc !== e.cyc + 1) begin
            fails++;
            $display("FAIL ch_write: got addr %0d data %h cycle %0d, required addr %0d data %h cycle %0d",
                     ch_addr, ch_data, cyc, e.a, e.d, e.cyc + 1);
          end
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic e, input logic push,
                           input logic [3:0] a, input logic [10:0] val);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = d;
    byte_err   = e;
    if (push) exp_q.push_back('{a: a, d: val, cyc: cyc});
    @(negedge clk);
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    byte_data  = '0;
  endtask

  // err_at: data byte index sent with byte_err (then stop); n_data < 22 stops early
  task automatic send_frame(input logic [175:0] p, input logic [7:0] flags, input logic [7:0] ftr,
                            input int err_at, input int n_data);
    int   c0, c1;
    logic e;
    send_byte(8'h0F, 1'b0, 1'b0, 4'd0, 11'd0);
    for (int i = 0; i < 22 && i < n_data; i++) begin
      c0 = (8 * i) / 11;
      c1 = (8 * (i + 1)) / 11;
      e  = (i == err_at);
      send_byte(p[8*i +: 8], e, !e && (c1 != c0), 4'(c0), p[11*c0 +: 11]);
      if (e) return;
    end
    if (n_data < 22) return;
    send_byte(flags, 1'b0, 1'b0, 4'd0, 11'd0);
    send_byte(ftr, 1'b0, 1'b0, 4'd0, 11'd0);
  endtask

  function automatic logic [175:0] rand_payload();
    logic [175:0] p;
    for (int k = 0; k < 16; k++) p[11*k +: 11] = 11'($urandom);
    return p;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++;
    if ({ch_we, frame_ok, frame_abort, ch17, ch18, failsafe, link_lost} !== 7'b0000011) begin
      fails++;
      $display("FAIL reset_flags: got %b, required 0000011",
               {ch_we, frame_ok, frame_abort, ch17, ch18, failsafe, link_lost});
    end
    checks++;
    if (err_cnt !== 8'd0 || ch_addr !== 4'd0 || ch_data !== 11'd0) begin
      fails++;
      $display("FAIL reset_regs: got err %0d addr %0d data %h, required 0 0 0", err_cnt, ch_addr, ch_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_good_frame();
    logic [175:0] p;
    int ok_b = ok0, ab_b = ab0;
    for (int k = 0; k < 16; k++) p[11*k +: 11] = 11'h400;
    idle(1200);
    send_frame(p, 8'h03, 8'h00, -1, 22);
    checks++;
    if (frame_ok !== 1'b0) begin
      fails++; $display("FAIL good_ok_early: got %b, required 0", frame_ok);
    end
    @(negedge clk);
    checks++;
    if (frame_ok !== 1'b1) begin
      fails++; $display("FAIL good_ok_latency: got %b, required 1", frame_ok);
    end
    idle(3);
    checks++;
    if (ok0 - ok_b !== 1 || ab0 - ab_b !== 0) begin
      fails++; $display("FAIL good_pulses: got ok %0d abort %0d, required 1 0", ok0 - ok_b, ab0 - ab_b);
    end
    checks++;
    if ({ch17, ch18, failsafe, link_lost} !== 4'b1100) begin
      fails++; $display("FAIL good_status: got %b, required 1100", {ch17, ch18, failsafe, link_lost});
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL good_writes_missing: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_gap();
    int ok_b = ok0, ab_b = ab0;
    idle(500);
    send_byte(8'h0F, 1'b0, 1'b0, 4'd0, 11'd0);
    for (int i = 0; i < 4; i++) send_byte(8'h55, 1'b0, 1'b0, 4'd0, 11'd0);
    idle(20);
    checks++;
    if (ab0 - ab_b !== 0 || ok0 - ok_b !== 0) begin
      fails++; $display("FAIL gap_short_hdr: got ok %0d abort %0d, required 0 0", ok0 - ok_b, ab0 - ab_b);
    end
    idle(990);
    send_frame(rand_payload(), 8'h00, 8'h00, -1, 22);
    idle(4);
    checks++;
    if (ok0 - ok_b !== 1 || ab0 - ab_b !== 0) begin
      fails++; $display("FAIL gap_long_hdr: got ok %0d abort %0d, required 1 0", ok0 - ok_b, ab0 - ab_b);
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL gap_writes_missing: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_byte_err();
    int ok_b = ok0, ab_b = ab0;
    idle(1200);
    send_frame(rand_payload(), 8'h00, 8'h00, 7, 22);
    idle(5);
    checks++;
    if (ab0 - ab_b !== 1 || ok0 - ok_b !== 0 || err_cnt !== 8'd1) begin
      fails++;
      $display("FAIL err_abort: got abort %0d ok %0d err_cnt %0d, required 1 0 1", ab0 - ab_b, ok0 - ok_b, err_cnt);
    end
    idle(1200);
    send_frame(rand_payload(), 8'h00, 8'h00, -1, 22);
    idle(4);
    checks++;
    if (ok0 - ok_b !== 1 || ab0 - ab_b !== 1 || err_cnt !== 8'd1) begin
      fails++;
      $display("FAIL err_recover: got ok %0d abort %0d err_cnt %0d, required 1 1 1", ok0 - ok_b, ab0 - ab_b, err_cnt);
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL err_writes_missing: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    int ab_b = ab0;
    idle(1200);
    send_frame(rand_payload(), 8'h00, 8'h00, -1, 11);
    idle(1400);
    checks++;
    if (ab0 - ab_b !== 0) begin
      fails++; $display("FAIL stall_early: got abort %0d, required 0", ab0 - ab_b);
    end
    idle(200);
    checks++;
    if (ab0 - ab_b !== 1 || err_cnt !== 8'd2) begin
      fails++; $display("FAIL stall_abort: got abort %0d err_cnt %0d, required 1 2", ab0 - ab_b, err_cnt);
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL stall_writes_missing: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_footer_sbus2();
    int ok_b = ok0, ab_b = ab0, ok1_b = ok1, ab1_b = ab1;
    idle(1200);
    send_frame(rand_payload(), 8'h00, 8'h14, -1, 22);
    idle(4);
    checks++;
    if (ab0 - ab_b !== 1 || ok0 - ok_b !== 0 || err_cnt !== 8'd3) begin
      fails++;
      $display("FAIL ftr14_sbus1: got abort %0d ok %0d err_cnt %0d, required 1 0 3", ab0 - ab_b, ok0 - ok_b, err_cnt);
    end
    checks++;
    if (ok1 - ok1_b !== 1 || ab1 - ab1_b !== 0) begin
      fails++; $display("FAIL ftr14_sbus2: got ok %0d abort %0d, required 1 0", ok1 - ok1_b, ab1 - ab1_b);
    end
  endtask

  task automatic test_lost();
    int n;
    idle(1200);
    send_frame(rand_payload(), 8'h00, 8'h00, -1, 22);
    idle(3);
    checks++;
    if (link_lost !== 1'b0 || failsafe !== 1'b0) begin
      fails++; $display("FAIL lost_fresh: got link_lost %b failsafe %b, required 0 0", link_lost, failsafe);
    end
    idle(LOST - 100);
    checks++;
    if (link_lost !== 1'b0) begin
      fails++; $display("FAIL lost_early: got %b, required 0", link_lost);
    end
    n = 0;
    while (link_lost !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (link_lost !== 1'b1 || failsafe !== 1'b1) begin
      fails++; $display("FAIL lost_assert: got link_lost %b failsafe %b, required 1 1", link_lost, failsafe);
    end
    send_frame(rand_payload(), 8'h08, 8'h00, -1, 22);
    idle(4);
    checks++;
    if (link_lost !== 1'b0 || failsafe !== 1'b1) begin
      fails++; $display("FAIL lost_fs_flag: got link_lost %b failsafe %b, required 0 1", link_lost, failsafe);
    end
    idle(1200);
    send_frame(rand_payload(), 8'h00, 8'h00, -1, 22);
    idle(4);
    checks++;
    if (failsafe !== 1'b0) begin
      fails++; $display("FAIL lost_fs_clear: got %b, required 0", failsafe);
    end
  endtask

  task automatic test_reset_mid();
    int ok_b, ab_b;
    idle(1200);
    send_frame(rand_payload(), 8'h03, 8'h00, -1, 5);
    idle(2);
    rst = 1'b1;
    ok_b = ok0;
    ab_b = ab0;
    @(negedge clk);
    checks++;
    if ({ch_we, frame_ok, frame_abort, ch17, ch18, failsafe, link_lost} !== 7'b0000011 || err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL rst_mid_outputs: got %b err_cnt %0d, required 0000011 0",
               {ch_we, frame_ok, frame_abort, ch17, ch18, failsafe, link_lost}, err_cnt);
    end
    rst = 1'b0;
    idle(1700);
    checks++;
    if (ok0 - ok_b !== 0 || ab0 - ab_b !== 0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL rst_mid_pulses: got ok %0d abort %0d pending %0d, required 0 0 0",
               ok0 - ok_b, ab0 - ab_b, exp_q.size());
    end
    send_frame(rand_payload(), 8'h03, 8'h00, -1, 22);
    idle(4);
    checks++;
    if (ok0 - ok_b !== 1 || {ch17, ch18} !== 2'b11) begin
      fails++; $display("FAIL rst_mid_recover: got ok %0d ch17/18 %b, required 1 11", ok0 - ok_b, {ch17, ch18});
    end
  endtask

  initial begin
    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_data  = '0;
    byte_err   = 1'b0;
    fork
      scoreboard_mon();
    join_none
    test_reset();
    test_good_frame();
    test_gap();
    test_byte_err();
    test_stall();
    test_footer_sbus2();
    test_lost();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
